pri_arbiter_16: RTL and testbench
=================================

Name: pri_arbiter_16

Overview:
- 16-requester arbiter sharing one resource; built around a 16:4 priority encoder.
- Registers a one-hot grant plus its 4-bit binary index and holds it until the owner releases.
- Enforces a hold timeout and inserts a one-cycle turnaround between owners.
- Sits in front of any shared datapath (bus, memory port) in the coder/decoder family.

Parameters:
- MAX_HOLD, 64, maximum cycles a grant may be held before forced release (1..65535).
- CNT_W, 16, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  arbitration enable; gates new grants only.
- req  input  16  request vector; bit i = requester i.
- done  input  1  owner release strobe, single-cycle, qualified by gnt_valid.
- gnt  output  16  one-hot grant, registered.
- gnt_id  output  4  binary index of current owner, registered.
- gnt_valid  output  1  grant active.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, reset_n=0):
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - State=IDLE, hold counter=0, round-robin pointer=15.
- Three states: IDLE, GRANT, TURN.
- IDLE:
  - If enable=1 and req!=0, encode req, go to GRANT.
  - gnt, gnt_id and gnt_valid become valid on the next edge; latency is 1 cycle from req sample to gnt_valid.
  - Otherwise stay in IDLE.
- GRANT:
  - Counter increments every cycle and starts at 0 on the first GRANT cycle.
  - Release condition: done=1, OR req[gnt_id]=0 (requester withdrew), OR counter==MAX_HOLD-1.
  - On release go to TURN; gnt, gnt_valid and the counter clear on that edge; gnt_id keeps the last owner.
  - timeout=1 for exactly the TURN cycle only when the release was forced (counter limit reached without done or withdrawal).
  - If done and the limit coincide, done wins and there is no timeout pulse.
- TURN:
  - One dead cycle; no grant. Always return to IDLE.
  - The minimum gap between consecutive grants is therefore 2 cycles (TURN + IDLE sample).
- enable:
  - Deassert during GRANT: current grant continues to normal release; no new grant while enable=0.
  - Enable affects the IDLE decision only.
- Encoding (fixed priority, default):
  - Lowest set bit wins; bit 0 highest priority.
  - Matches the team's 16:4 priority encoder mapping (bit i -> index i).
- req changes on non-owner bits during GRANT are ignored.
- Mid-operation reset: immediate return to IDLE with reset values; no timeout pulse.
- gnt is always one-hot or zero, and gnt[gnt_id]=1 whenever gnt_valid=1.

Optional Feature:
- Macro: PRI_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority. The pointer is updated to gnt_id at each grant.
  - The next search starts at pointer+1 (mod 16) and wraps, so the most recent owner is lowest priority.
  - Implementation: rotate req right by pointer+1, encode, add pointer+1 mod 16.
- Undefined:
  - Fixed priority as above. Pointer logic is absent and reset of the pointer is irrelevant.

Decomposition:
- Package pri_arb_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_TURN=2'd2.
  - Constant NREQ=16, IDW=4.
- Sub-module pri_encoder_16:
  - Combinational 16->4 lowest-set-bit encoder with a valid output (any bit set).
  - Instantiated once; used on raw req (fixed mode) or rotated req (round-robin mode).
- FSM, counter, pointer and output registers live in pri_arbiter_16.

Test Plan:
- Reset/idle: reset_n=0 with req=16'hFFFF -> all outputs 0. Release reset with enable=0 -> gnt_valid stays 0.
- Fixed priority: enable=1, req=16'h8014 -> next cycle gnt=16'h0004, gnt_id=2. Pulse done -> TURN, IDLE, then gnt_id=4 two cycles after TURN entry.
- Withdrawal: owner id 4 drops req[4] without done -> release, no timeout. Next grant id 15 when req=16'h8000.
- Timeout: MAX_HOLD=8, req=16'h0001 held, done never -> gnt_valid high exactly 8 cycles, timeout pulses 1 cycle, then id 0 regranted after IDLE.
- Enable drop mid-grant: grant id 3, enable=0, done later -> release completes; no new grant while enable=0 despite req!=0.
- Round robin (PRI_ARBITER_ROUND_ROBIN_EN): req=16'h0013 constant, done each grant -> gnt_id sequence 0,1,4,0,1,4. Reset mid-grant -> outputs clear immediately, sequence restarts at 0.

Source files
------------

// File: rtl/pri_arb_pkg.sv
// pri_arb_pkg: shared constants and state encoding for the 16-requester arbiter
package pri_arb_pkg;
    localparam int NREQ = 16;
    localparam int IDW  = 4;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;
endpackage

// File: rtl/pri_encoder_16.sv
// pri_encoder_16: combinational 16:4 lowest-set-bit priority encoder
// Ports: in (request bits), idx (index of lowest set bit), valid (any bit set)
module pri_encoder_16
    import pri_arb_pkg::*;
(
    input  logic [NREQ-1:0] in,
    output logic [IDW-1:0]  idx,
    output logic            valid
);
    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (in[i]) idx = IDW'(i);
    end
    assign valid = |in;
endmodule

// File: rtl/pri_arbiter_16.sv
// pri_arbiter_16: 16-requester arbiter with hold timeout and one-cycle turnaround
// Ports: clk, reset_n (async active-low), enable (gates new grants), req[15:0],
//        done (owner release strobe), gnt[15:0] one-hot, gnt_id[3:0], gnt_valid,
//        timeout (one-cycle pulse on forced release).
// Build option: define PRI_ARBITER_ROUND_ROBIN_EN for rotating priority;
//               otherwise bit 0 always has highest priority.
module pri_arbiter_16
    import pri_arb_pkg::*;
#(
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_valid,
    output logic            timeout
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [NREQ-1:0]  enc_in;
    logic [IDW-1:0]   enc_idx;
    logic             enc_valid;
    logic [IDW-1:0]   win_id;
    logic             at_limit;
    logic             rel;
    logic             forced;

`ifdef PRI_ARBITER_ROUND_ROBIN_EN
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] start;
    // Rotate so the slot after the last owner lands on bit 0, then undo the rotation.
    assign start  = ptr + 1'b1;
    assign enc_in = NREQ'({req, req} >> start);
    assign win_id = enc_idx + start;
`else
    assign enc_in = req;
    assign win_id = enc_idx;
`endif

    pri_encoder_16 u_enc (
        .in    (enc_in),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign at_limit = cnt == CNT_W'(MAX_HOLD - 1);
    assign rel      = done || !req[gnt_id] || at_limit;
    // A release caused by done or withdrawal is never reported as a timeout.
    assign forced   = at_limit && !done && req[gnt_id];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
`ifdef PRI_ARBITER_ROUND_ROBIN_EN
            ptr       <= 4'd15;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (enable && enc_valid) begin
                        state     <= ST_GRANT;
                        cnt       <= '0;
                        gnt       <= NREQ'(1) << win_id;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
`ifdef PRI_ARBITER_ROUND_ROBIN_EN
                        ptr       <= win_id;
`endif
                    end
                end
                ST_GRANT: begin
                    if (rel) begin
                        state     <= ST_TURN;
                        cnt       <= '0;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        timeout   <= forced;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_TURN: begin
                    state   <= ST_IDLE;
                    timeout <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pri_arbiter_16.sv
// tb_pri_arbiter_16: directed bench with a per-cycle reference model for pri_arbiter_16
module tb_pri_arbiter_16;
    localparam int MAX_HOLD = 8;
`ifdef PRI_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
    int seq [6] = '{0, 1, 4, 0, 1, 4};
`else
    localparam bit RR = 1'b0;
    int seq [6] = '{0, 0, 0, 0, 0, 0};
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    pri_arbiter_16 #(.MAX_HOLD(MAX_HOLD), .CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 = none), cycles held, pending dead cycle.
    int m_owner, m_held, m_last, m_ptr, p;
    bit m_dead, m_to;

    function automatic int pick(logic [15:0] r, int start);
        for (int k = 0; k < 16; k++)
            if (r[(start + k) % 16]) return (start + k) % 16;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_owner = -1; m_held = 0; m_last = 0; m_ptr = 15; m_dead = 0; m_to = 0;
        end else if (m_owner >= 0) begin
            m_held++;
            if (done || !req[m_owner] || m_held == MAX_HOLD) begin
                m_to    = !done && req[m_owner];
                m_owner = -1;
                m_dead  = 1;
                m_held  = 0;
            end
        end else if (m_dead) begin
            m_dead = 0;
            m_to   = 0;
        end else begin
            m_to = 0;
            p = pick(req, RR ? (m_ptr + 1) % 16 : 0);
            if (enable && p >= 0) begin
                m_owner = p; m_last = p; m_ptr = p; m_held = 0;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_gnt", 32'(gnt), m_owner >= 0 ? 32'(1) << m_owner : 32'd0);
        chk("model_gnt_id", 32'(gnt_id), 32'(m_last));
        chk("model_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("model_timeout", 32'(timeout), 32'(m_to));
    end

    task automatic cyc(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_o(string nm, logic [15:0] g, logic [3:0] id, logic v, logic t);
        chk({nm, ".gnt"}, 32'(gnt), 32'(g));
        chk({nm, ".gnt_id"}, 32'(gnt_id), 32'(id));
        chk({nm, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
        chk({nm, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    task automatic wait_grant();
        for (int w = 0; w < 10 && !gnt_valid; w++) cyc();
        chk("grant_wait", 32'(gnt_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; req = 16'hFFFF; done = 1'b0;
        cyc(2);
        expect_o("reset", 16'h0, 4'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        cyc(3);
        expect_o("idle_disabled", 16'h0, 4'd0, 1'b0, 1'b0);
        // Fixed priority: lowest bit of 8014 is 2.
        enable = 1'b1; req = 16'h8014;
        cyc();
        expect_o("first_grant", 16'h0004, 4'd2, 1'b1, 1'b0);
        done = 1'b1; req = 16'h8010;
        cyc();
        expect_o("turn_after_done", 16'h0, 4'd2, 1'b0, 1'b0);
        done = 1'b0;
        cyc();
        expect_o("idle_gap", 16'h0, 4'd2, 1'b0, 1'b0);
        cyc();
        expect_o("second_grant", 16'h0010, 4'd4, 1'b1, 1'b0);
        // Withdrawal by owner 4.
        req = 16'h8000;
        cyc();
        expect_o("withdraw", 16'h0, 4'd4, 1'b0, 1'b0);
        cyc(2);
        expect_o("grant_15", 16'h8000, 4'd15, 1'b1, 1'b0);
        req = 16'h0;
        cyc(3);
        expect_o("all_idle", 16'h0, 4'd15, 1'b0, 1'b0);
        // Forced release after MAX_HOLD cycles.
        req = 16'h0001;
        cyc();
        expect_o("hold_1", 16'h0001, 4'd0, 1'b1, 1'b0);
        for (int i = 2; i <= MAX_HOLD; i++) begin
            cyc();
            chk("hold_valid", 32'(gnt_valid), 32'd1);
        end
        cyc();
        expect_o("timeout_pulse", 16'h0, 4'd0, 1'b0, 1'b1);
        cyc();
        expect_o("timeout_clear", 16'h0, 4'd0, 1'b0, 1'b0);
        cyc();
        expect_o("regrant_0", 16'h0001, 4'd0, 1'b1, 1'b0);
        // done on the limit cycle suppresses the timeout pulse.
        cyc(MAX_HOLD - 1);
        done = 1'b1;
        cyc();
        expect_o("done_wins", 16'h0, 4'd0, 1'b0, 1'b0);
        done = 1'b0; req = 16'h0;
        cyc(2);
        // Enable drop mid-grant.
        req = 16'h0008;
        cyc();
        expect_o("grant_3", 16'h0008, 4'd3, 1'b1, 1'b0);
        enable = 1'b0; req = 16'h0018;
        cyc(2);
        chk("grant_kept_disabled", 32'(gnt_valid), 32'd1);
        done = 1'b1;
        cyc();
        expect_o("release_disabled", 16'h0, 4'd3, 1'b0, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("no_grant_disabled", 32'(gnt_valid), 32'd0);
        end
        enable = 1'b1;
        cyc();
        expect_o("reenable", RR ? 16'h0010 : 16'h0008, RR ? 4'd4 : 4'd3, 1'b1, 1'b0);
        // Mid-grant asynchronous reset.
        #2 reset_n = 1'b0;
        #1 expect_o("mid_reset", 16'h0, 4'd0, 1'b0, 1'b0);
        req = 16'h0013;
        cyc();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_grant();
            chk("seq_id", 32'(gnt_id), 32'(seq[k]));
            done = 1'b1;
            cyc();
            done = 1'b0;
        end
        wait_grant();
        chk("seq2_id0", 32'(gnt_id), 32'(seq[0]));
        done = 1'b1; cyc(); done = 1'b0;
        wait_grant();
        chk("seq2_id1", 32'(gnt_id), 32'(seq[1]));
        #2 reset_n = 1'b0;
        #1 expect_o("reset_in_seq", 16'h0, 4'd0, 1'b0, 1'b0);
        cyc();
        reset_n = 1'b1;
        wait_grant();
        chk("restart_id", 32'(gnt_id), 32'd0);
        req = 16'h0;
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
